// File: rtl/axi4_mem_responder.sv
// AXI4 slave memory model: independent write (AW/W/B) and read (AR/R) engines over a
// register-array memory supporting full-width INCR/FIXED bursts with byte strobes.
module axi4_mem_responder #(
   parameter int unsigned ID_WIDTH      = 6,
   parameter int unsigned ADDR_WIDTH    = 64,
   parameter int unsigned DATA_WIDTH    = 256,
   parameter int unsigned MEM_DEPTH_LG2 = 6
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      s_axi_awvalid,
   output logic                      s_axi_awready,
   input  logic [ID_WIDTH-1:0]       s_axi_awid,
   input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
   input  logic [7:0]                s_axi_awlen,
   input  logic [2:0]                s_axi_awsize,
   input  logic [1:0]                s_axi_awburst,
   input  logic [3:0]                s_axi_awcache,
   input  logic [2:0]                s_axi_awprot,
   input  logic [3:0]                s_axi_awqos,
   input  logic [3:0]                s_axi_awregion,
   input  logic                      s_axi_wvalid,
   output logic                      s_axi_wready,
   input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
   input  logic                      s_axi_wlast,
   output logic                      s_axi_bvalid,
   input  logic                      s_axi_bready,
   output logic [ID_WIDTH-1:0]       s_axi_bid,
   output logic [1:0]                s_axi_bresp,
   input  logic                      s_axi_arvalid,
   output logic                      s_axi_arready,
   input  logic [ID_WIDTH-1:0]       s_axi_arid,
   input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
   input  logic [7:0]                s_axi_arlen,
   input  logic [2:0]                s_axi_arsize,
   input  logic [1:0]                s_axi_arburst,
   input  logic [3:0]                s_axi_arcache,
   input  logic [2:0]                s_axi_arprot,
   input  logic [3:0]                s_axi_arqos,
   input  logic [3:0]                s_axi_arregion,
   output logic                      s_axi_rvalid,
   input  logic                      s_axi_rready,
   output logic [ID_WIDTH-1:0]       s_axi_rid,
   output logic [DATA_WIDTH-1:0]     s_axi_rdata,
   output logic [1:0]                s_axi_rresp,
   output logic                      s_axi_rlast
);

   localparam int unsigned StrbWidth = DATA_WIDTH / 8;
   localparam int unsigned Depth     = 1 << MEM_DEPTH_LG2;
   localparam int unsigned IdxLsb    = 5;
   localparam logic [MEM_DEPTH_LG2-1:0] IdxOne = {{(MEM_DEPTH_LG2-1){1'b0}}, 1'b1};
   localparam logic [1:0] RespOkay   = 2'b00;
   localparam logic [1:0] RespSlvErr = 2'b10;

   typedef enum logic [1:0] {StWIdle, StWData, StWResp} w_state_e;
   typedef enum logic {StRIdle, StRData} r_state_e;

   logic [DATA_WIDTH-1:0] r_mem [Depth];

   // ---------------- request decode ----------------
   logic                     w_aw_err, w_ar_err;
   logic [MEM_DEPTH_LG2-1:0] w_aw_idx, w_ar_idx;
   logic                     w_unused;

   assign w_aw_err = (s_axi_awaddr[ADDR_WIDTH-1:IdxLsb+MEM_DEPTH_LG2] != '0) ||
                     (s_axi_awsize != 3'd5) || s_axi_awburst[1];
   assign w_ar_err = (s_axi_araddr[ADDR_WIDTH-1:IdxLsb+MEM_DEPTH_LG2] != '0) ||
                     (s_axi_arsize != 3'd5) || s_axi_arburst[1];
   assign w_aw_idx = s_axi_awaddr[IdxLsb +: MEM_DEPTH_LG2];
   assign w_ar_idx = s_axi_araddr[IdxLsb +: MEM_DEPTH_LG2];
   assign w_unused = ^{s_axi_awcache, s_axi_awprot, s_axi_awqos, s_axi_awregion,
                       s_axi_arcache, s_axi_arprot, s_axi_arqos, s_axi_arregion,
                       s_axi_awaddr[IdxLsb-1:0], s_axi_araddr[IdxLsb-1:0]};

   // ---------------- write engine ----------------
   w_state_e                 r_wstate;
   logic                     r_awready, r_wready, r_bvalid;
   logic [1:0]               r_bresp;
   logic [ID_WIDTH-1:0]      r_bid;
   logic [MEM_DEPTH_LG2-1:0] r_widx;
   logic [7:0]               r_wlen;
   logic                     r_wincr, r_werr;
   logic [8:0]               r_wcnt;
   logic                     w_w_hs, w_wr_en;

   assign w_w_hs  = s_axi_wvalid && r_wready;
   assign w_wr_en = w_w_hs && !r_werr && (r_wcnt <= {1'b0, r_wlen});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wstate  <= StWIdle;
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_bvalid  <= 1'b0;
         r_bresp   <= RespOkay;
         r_bid     <= '0;
         r_widx    <= '0;
         r_wlen    <= '0;
         r_wincr   <= 1'b0;
         r_werr    <= 1'b0;
         r_wcnt    <= '0;
      end else begin
         unique case (r_wstate)
            StWIdle: begin
               r_awready <= 1'b1;
               if (s_axi_awvalid && r_awready) begin
                  r_awready <= 1'b0;
                  r_wready  <= 1'b1;
                  r_bid     <= s_axi_awid;
                  r_widx    <= w_aw_idx;
                  r_wlen    <= s_axi_awlen;
                  r_wincr   <= (s_axi_awburst == 2'b01);
                  r_werr    <= w_aw_err;
                  r_wcnt    <= '0;
                  r_wstate  <= StWData;
               end
            end
            StWData: begin
               if (w_w_hs) begin
                  if (r_wincr) r_widx <= r_widx + IdxOne;
                  // Saturate so runaway bursts can never alias back to a legal count.
                  if (r_wcnt != 9'h1FF) r_wcnt <= r_wcnt + 9'd1;
                  if (s_axi_wlast) begin
                     r_wready <= 1'b0;
                     r_bvalid <= 1'b1;
                     r_bresp  <= (r_werr || (r_wcnt != {1'b0, r_wlen})) ? RespSlvErr : RespOkay;
                     r_wstate <= StWResp;
                  end
               end
            end
            StWResp: begin
               if (s_axi_bready) begin
                  r_bvalid  <= 1'b0;
                  r_awready <= 1'b1;
                  r_wstate  <= StWIdle;
               end
            end
            default: r_wstate <= StWIdle;
         endcase
      end
   end

   // Memory is deliberately not reset.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         for (int b = 0; b < StrbWidth; b++) begin
            if (s_axi_wstrb[b]) r_mem[r_widx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
         end
      end
   end

   // ---------------- read engine ----------------
   r_state_e                 r_rstate;
   logic                     r_arready, r_rvalid, r_rlast;
   logic [DATA_WIDTH-1:0]    r_rdata;
   logic [1:0]               r_rresp;
   logic [ID_WIDTH-1:0]      r_rid;
   logic [MEM_DEPTH_LG2-1:0] r_ridx;
   logic [7:0]               r_rlen, r_rcnt;
   logic                     r_rincr, r_rerr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rstate  <= StRIdle;
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rlast   <= 1'b0;
         r_rdata   <= '0;
         r_rresp   <= RespOkay;
         r_rid     <= '0;
         r_ridx    <= '0;
         r_rlen    <= '0;
         r_rcnt    <= '0;
         r_rincr   <= 1'b0;
         r_rerr    <= 1'b0;
      end else begin
         unique case (r_rstate)
            StRIdle: begin
               r_arready <= 1'b1;
               if (s_axi_arvalid && r_arready) begin
                  r_arready <= 1'b0;
                  r_rvalid  <= 1'b1;
                  r_rid     <= s_axi_arid;
                  r_rlen    <= s_axi_arlen;
                  r_rincr   <= (s_axi_arburst == 2'b01);
                  r_rerr    <= w_ar_err;
                  r_rresp   <= w_ar_err ? RespSlvErr : RespOkay;
                  r_rdata   <= w_ar_err ? '0 : r_mem[w_ar_idx];
                  r_ridx    <= (s_axi_arburst == 2'b01) ? w_ar_idx + IdxOne : w_ar_idx;
                  r_rcnt    <= '0;
                  r_rlast   <= (s_axi_arlen == 8'd0);
                  r_rstate  <= StRData;
               end
            end
            StRData: begin
               if (s_axi_rready) begin
                  if (r_rlast) begin
                     r_rvalid  <= 1'b0;
                     r_rlast   <= 1'b0;
                     r_arready <= 1'b1;
                     r_rstate  <= StRIdle;
                  end else begin
                     // r_ridx already points at the next beat's word.
                     r_rdata <= r_rerr ? '0 : r_mem[r_ridx];
                     if (r_rincr) r_ridx <= r_ridx + IdxOne;
                     r_rcnt  <= r_rcnt + 8'd1;
                     r_rlast <= ((r_rcnt + 8'd1) == r_rlen);
                  end
               end
            end
            default: r_rstate <= StRIdle;
         endcase
      end
   end

   assign s_axi_awready = r_awready;
   assign s_axi_wready  = r_wready;
   assign s_axi_bvalid  = r_bvalid;
   assign s_axi_bresp   = r_bresp;
   assign s_axi_bid     = r_bid;
   assign s_axi_arready = r_arready;
   assign s_axi_rvalid  = r_rvalid;
   assign s_axi_rlast   = r_rlast;
   assign s_axi_rdata   = r_rdata;
   assign s_axi_rresp   = r_rresp;
   assign s_axi_rid     = r_rid;

endmodule

// File: doc/axi4_mem_responder.md
# axi4_mem_responder

AXI4 slave memory model that answers the PCIe core's outbound AXI master port (m_axi_* of the PCIe top), i.e. the responder end of the DMA-issued AXI traffic. It implements independent write (AW/W/B) and read (AR/R) state machines over a synchronous register-array memory with full-width INCR/FIXED bursts and byte strobes. It is used as the host-memory endpoint in system simulation and as the BAR-backing memory in FPGA builds.

## Interface
- ID_WIDTH, 6, AXI ID width
- ADDR_WIDTH, 64, AXI address width
- DATA_WIDTH, 256, data width; STRB width = DATA_WIDTH/8 = 32
- MEM_DEPTH_LG2, 6, log2 of memory depth in DATA_WIDTH words (default 64 words = 2 KiB)

Ports (clock and reset first; one clock; reset is asynchronous and active-high):
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous active-high reset
- s_axi_awvalid / s_axi_awready  in / out  1  AW handshake
- s_axi_awid  in  ID_WIDTH  write ID, returned on bid
- s_axi_awaddr  in  ADDR_WIDTH  byte address of first beat
- s_axi_awlen  in  8  beats minus 1
- s_axi_awsize  in  3  must be 5 (32 B)
- s_axi_awburst  in  2  0 FIXED, 1 INCR, 2 WRAP (unsupported)
- s_axi_awcache, awprot, awqos, awregion  in  4/3/4/4  accepted, ignored
- s_axi_wvalid / s_axi_wready  in / out  1  W handshake
- s_axi_wdata  in  DATA_WIDTH  write data
- s_axi_wstrb  in  DATA_WIDTH/8  byte enables
- s_axi_wlast  in  1  last write beat
- s_axi_bvalid / s_axi_bready  out / in  1  B handshake
- s_axi_bid  out  ID_WIDTH  = captured awid
- s_axi_bresp  out  2  0 OKAY, 2 SLVERR
- s_axi_ar*  in  same widths as AW  read address channel, same meaning
- s_axi_rvalid / s_axi_rready  out / in  1  R handshake
- s_axi_rid  out  ID_WIDTH  = captured arid
- s_axi_rdata  out  DATA_WIDTH  read data
- s_axi_rresp  out  2  0 OKAY, 2 SLVERR
- s_axi_rlast  out  1  last read beat

## Operation
- Word index = addr[5 +: MEM_DEPTH_LG2]; addr[4:0] ignored (aligned beats only).
- Request error (SLVERR): addr[ADDR_WIDTH-1 : 5+MEM_DEPTH_LG2] nonzero, or size != 5, or burst == WRAP/reserved.
- INCR: index += 1 per beat, wraps modulo 2^MEM_DEPTH_LG2. FIXED: index constant.
- Write FSM: W_IDLE (awready=1) -> on AW handshake capture id/index/len/burst/err, beat counter = 0 -> W_DATA (wready=1). Each W handshake: if no error and counter <= len, write bytes where wstrb=1; counter += 1. On wlast handshake -> W_RESP (bvalid=1). bresp = SLVERR if request error or beat count (including last) != len+1; extra beats beyond len+1 are discarded. W_RESP -> W_IDLE on bready.
- Read FSM: R_IDLE (arready=1) -> on AR handshake capture id/index/len/burst/err -> R_DATA (rvalid=1). rlast=1 when beat counter == len. On R handshake with rlast -> R_IDLE; otherwise advance to next beat.
- rdata is a register, loaded from memory at AR handshake (beat 0) and at every non-last R handshake (next beat); on error rdata = 0, rresp = SLVERR on every beat.
- Read and write FSMs are fully independent; concurrent operation is allowed.

## Timing
- Reset values: awready=0, arready=0, wready=0, bvalid=0, rvalid=0, rlast=0, bresp=0, rresp=0, bid=0, rid=0, rdata=0; FSMs in IDLE. awready/arready rise the first cycle after rst deasserts. Memory contents are not reset.
- AW handshake at edge N -> wready=1 from cycle N+1; awready=0 until the cycle after the B handshake.
- wlast handshake at N -> bvalid=1 at N+1; wready=0 from N+1.
- AR handshake at N -> rvalid=1 with beat 0 at N+1; back-to-back beats at one per cycle while rready=1.
- rvalid, rdata, rresp, rlast, rid stay stable while rvalid && !rready; bvalid, bresp, bid stay stable while bvalid && !bready.
- Read load and write to the same word at the same edge: the read gets the old data.
- rst asserted mid-burst: both FSMs return to IDLE immediately; partial writes already committed remain in memory.

## Test plan
- Write INCR awaddr=0x40, awlen=3, wstrb all ones, data 0xA0..0xA3 -> bvalid the cycle after wlast, bresp=0, bid=awid; read the same address with arlen=3 -> rdata 0xA0..0xA3, rlast on beat 3, rresp=0.
- Strobe: write 0xFF..FF to word 5, then wstrb=0x0000_0001 with data 0 -> read word 5 returns low byte 0x00, all other bytes 0xFF.
- Wrap and FIXED: INCR write at index 63, awlen=1 -> second beat lands at index 0; FIXED awlen=2 -> only the last beat's data remains in the word.
- Errors: awaddr=0x1_0000_0000 -> bresp=2, memory unchanged; arsize=4 -> every beat rresp=2, rdata=0; wlast on beat 2 with awlen=3 -> bresp=2.
- Backpressure: rready toggled 1,0,0,1 and bready held 0 for 5 cycles -> R/B outputs stable while stalled, no beat lost or duplicated.
- Concurrent write to word 8 with read of word 8 at the same edge -> the read returns old data; assert rst mid-read-burst -> rvalid=0 next cycle, arready=1 the cycle after rst deasserts.
